// File: rtl/key_debounce.sv
// key_debounce: per-key synchroniser, polarity normalisation and stability-counter debounce FSM
module key_debounce #(
  parameter int N_KEYS        = 2,
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 19,
  parameter int ACTIVE_LOW_IN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse
);
  localparam logic [N_KEYS-1:0] IDLE = (ACTIVE_LOW_IN != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  typedef enum logic [1:0] {UP, ARM_DN, DOWN, ARM_UP} state_t;
  logic [N_KEYS-1:0] sync1, sync2, s;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  // XOR with the released level makes s active-high "pressed" for either polarity
  assign s = sync2 ^ IDLE;
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic press_nx, release_nx;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        state            <= UP;
        cnt              <= '0;
        press_pulse[i]   <= 1'b0;
        release_pulse[i] <= 1'b0;
      end else begin
        state            <= state_nx;
        cnt              <= cnt_nx;
        press_pulse[i]   <= press_nx;
        release_pulse[i] <= release_nx;
      end
    always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      case (state)
        UP: if (s[i]) begin
          state_nx = ARM_DN;
          cnt_nx   = CNT_W'(1);
        end
        ARM_DN: if (!s[i]) begin
          state_nx = UP;
          cnt_nx   = '0;
        end else if (cnt == LAST) begin
          state_nx = DOWN;
          cnt_nx   = '0;
          press_nx = 1'b1;
        end else cnt_nx = cnt + 1'b1;
        DOWN: if (!s[i]) begin
          state_nx = ARM_UP;
          cnt_nx   = CNT_W'(1);
        end
        ARM_UP: if (s[i]) begin
          state_nx = DOWN;
          cnt_nx   = '0;
        end else if (cnt == LAST) begin
          state_nx   = UP;
          cnt_nx     = '0;
          release_nx = 1'b1;
        end else cnt_nx = cnt + 1'b1;
      endcase
    end
    assign key_out[i] = (state == DOWN) || (state == ARM_UP);
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and random stimulus against a sample-history debounce model
module tb_key_debounce;
  localparam int S = 8;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [1:0] key_raw = 2'b11;
  logic [1:0] key_out, press_pulse, release_pulse;
  int errors = 0, checks = 0;

  key_debounce #(.N_KEYS(2), .STABLE_CYCLES(S), .CNT_W(3), .ACTIVE_LOW_IN(1)) dut (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw),
    .key_out(key_out), .press_pulse(press_pulse), .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // Model: the debounced level flips once the last S synchronised samples all disagree with it.
  logic [1:0] p1, p2, m_out, m_press, m_rel;
  logic [S-1:0] hist [2];
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      p1 <= '0; p2 <= '0; m_out <= '0; m_press <= '0; m_rel <= '0;
      hist[0] <= '0; hist[1] <= '0;
    end else begin
      p1 <= ~key_raw;
      p2 <= p1;
      for (int k = 0; k < 2; k++) begin
        logic [S-1:0] h;
        h = {hist[k][S-2:0], p2[k]};
        hist[k] <= h;
        m_press[k] <= 1'b0;
        m_rel[k] <= 1'b0;
        if (!m_out[k] && h == '1) begin m_out[k] <= 1'b1; m_press[k] <= 1'b1; end
        else if (m_out[k] && h == '0) begin m_out[k] <= 1'b0; m_rel[k] <= 1'b1; end
      end
    end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      checks++;
      assert (key_out === m_out) else begin errors++; $error("FAIL key_out got=%b exp=%b t=%0t", key_out, m_out, $time); end
      checks++;
      assert (press_pulse === m_press) else begin errors++; $error("FAIL press_pulse got=%b exp=%b t=%0t", press_pulse, m_press, $time); end
      checks++;
      assert (release_pulse === m_rel) else begin errors++; $error("FAIL release_pulse got=%b exp=%b t=%0t", release_pulse, m_rel, $time); end
    end
  endtask

  task automatic expect_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin errors++; $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time); end
  endtask

  initial begin
    int n;
    cyc(3);
    reset_n = 1'b1;
    // 1: idle with keys released
    cyc(100);
    expect_bit("idle_out", |key_out, 1'b0);
    // 2: clean press on key 0, 9 clocks from the first sampling edge
    key_raw[0] = 1'b0;
    for (int i = 0; i < 9; i++) begin cyc(1); expect_bit("press_early", key_out[0], 1'b0); end
    cyc(1);
    expect_bit("press_edge", key_out[0], 1'b1);
    expect_bit("press_pulse", press_pulse[0], 1'b1);
    cyc(1);
    expect_bit("press_pulse_1clk", press_pulse[0], 1'b0);
    key_raw[0] = 1'b1;
    cyc(15);
    expect_bit("released", key_out[0], 1'b0);
    // 3: bouncing every 3 clocks, then held low
    for (int i = 0; i < 20; i++) begin key_raw[0] = ~key_raw[0]; cyc(3); expect_bit("bounce_hold", key_out[0], 1'b0); end
    key_raw[0] = 1'b0;
    cyc(15);
    expect_bit("bounce_press", key_out[0], 1'b1);
    // 4: release with a 7-clock low glitch during qualification
    key_raw[0] = 1'b1; cyc(3);
    key_raw[0] = 1'b0; cyc(7);
    expect_bit("glitch_hold", key_out[0], 1'b1);
    key_raw[0] = 1'b1;
    for (int i = 0; i < 9; i++) begin cyc(1); expect_bit("glitch_keep", key_out[0], 1'b1); end
    cyc(1);
    expect_bit("glitch_release", key_out[0], 1'b0);
    expect_bit("glitch_rel_pulse", release_pulse[0], 1'b1);
    cyc(5);
    // 5: both keys on the same edge, then key 1 alone released
    key_raw = 2'b00;
    n = 0;
    while (key_out !== 2'b11 && n < 30) begin cyc(1); n++; end
    expect_bit("dual_timeout", n < 30, 1'b1);
    expect_bit("dual_press", press_pulse === 2'b11, 1'b1);
    key_raw[1] = 1'b1;
    n = 0;
    while (key_out[1] !== 1'b0 && n < 30) begin cyc(1); n++; end
    expect_bit("rel1_timeout", n < 30, 1'b1);
    expect_bit("rel1_only", release_pulse === 2'b10, 1'b1);
    expect_bit("rel1_key0_held", key_out[0], 1'b1);
    key_raw = 2'b11;
    cyc(15);
    // 6: reset during qualification with the pin held pressed
    key_raw[0] = 1'b0;
    cyc(5);
    #1 reset_n = 1'b0;
    #1 expect_bit("reset_clears", |key_out, 1'b0);
    cyc(2);
    reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin cyc(1); expect_bit("rst_early", key_out[0], 1'b0); end
    cyc(1);
    expect_bit("rst_press", key_out[0], 1'b1);
    expect_bit("rst_pulse", press_pulse[0], 1'b1);
    // Random bursts: long holds interleaved with short bounces
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) if ($urandom_range(11) == 0) key_raw[k] = ~key_raw[k];
      cyc(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
